pipe_wbu: RTL and testbench

- Writeback stage of the 4-stage liang pipeline; sits directly downstream of the execute stage.
- Holds one instruction in a stage register and selects the writeback value (ALU result or load data).
- Owns the 32-entry integer register file, with two read ports for decode.
- Drives the WB→EX forward path, counts retired instructions, and halts the core on EBREAK.

---
 rtl/pipe_wbu.sv | 159 +++++++++++++++
 tb/tb_pipe_wbu.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_wbu.sv
// pipe_wbu: writeback stage of the 4-stage liang pipeline.
// It holds one instruction, selects ALU or load data for writeback, and owns
// the 32 x XLEN integer register file, which has two bypassed decode read ports.
// It also drives the WB->EX forward path, counts retired instructions and
// halts the core on EBREAK.
// Optional feature: define WBU_COMMIT_TRACE_EN to add the commit_* trace ports.

package pipe_wbu_pkg;
    typedef logic [31:0] ele_t;
    typedef logic [31:0] pc_t;

    typedef enum logic [2:0] {
        ALU    = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        BRANCH = 3'd3,
        EBREAK = 3'd4
    } fu_op_t;

    typedef struct packed {
        pc_t        pc;
        fu_op_t     fu_op;
        logic [4:0] rd;
        logic       rd_wen;
    } uop_info_t;

    typedef struct packed {
        uop_info_t uop_info;
        ele_t      alu_res;
        ele_t      lsu_res;
    } exToWb_t;
endpackage

module pipe_wbu
    import pipe_wbu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  exToWb_t          exToWb_i,
    input  logic             ex_valid_i,
    output logic             wb_ready_o,
    output logic             wb_fwd_valid_o,
    output logic [4:0]       wb_fwd_rd_o,
    output logic [XLEN-1:0]  wb_fwd_data_o,
    input  logic [4:0]       rf_raddr1_i,
    input  logic [4:0]       rf_raddr2_i,
    output logic [XLEN-1:0]  rf_rdata1_o,
    output logic [XLEN-1:0]  rf_rdata2_o,
    output logic             halt_o,
    output logic [XLEN-1:0]  halt_code_o,
`ifdef WBU_COMMIT_TRACE_EN
    output logic             commit_valid_o,
    output pc_t              commit_pc_o,
    output logic [XLEN-1:0]  commit_wdata_o,
`endif
    output logic [CNT_W-1:0] retire_cnt_o
);

    typedef enum logic {RUN, HALT} state_t;

    state_t            state_q, state_d;
    logic              wb_valid_q;
    exToWb_t           exToWb_q;
    logic              wb_fire;
    logic              rf_we;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   x10_rdata;
    logic [XLEN-1:0]   rf [32];
    logic [CNT_W-1:0]  retire_cnt_q;
    logic [XLEN-1:0]   halt_code_q;

    // Writeback data selection and write enable for the resident instruction
    always_comb begin
        wb_fire = wb_valid_q && (state_q == RUN);
        wdata   = (exToWb_q.uop_info.fu_op == LOAD) ? exToWb_q.lsu_res : exToWb_q.alu_res;
        rf_we   = wb_fire && exToWb_q.uop_info.rd_wen && (exToWb_q.uop_info.rd != 5'd0);
    end

    // Halt FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= RUN;
        else       state_q <= state_d;
    end

    // Halt FSM: next state; HALT is sticky until reset
    always_comb begin
        state_d = state_q;
        if (state_q == RUN && wb_fire && exToWb_q.uop_info.fu_op == EBREAK)
            state_d = HALT;
    end

    // Halt FSM: outputs
    always_comb begin
        halt_o     = (state_q == HALT);
        wb_ready_o = (state_q == RUN) && (!wb_valid_q || wb_fire);
    end

    // Stage valid bit; reset drops any in-flight instruction
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)           wb_valid_q <= 1'b0;
        else if (wb_ready_o) wb_valid_q <= ex_valid_i;
    end

    // Stage payload; not reset
    always_ff @(posedge clk_i) begin
        if (wb_ready_o) exToWb_q <= exToWb_i;
    end

    // Register file write port; contents are not reset, x0 never written
    always_ff @(posedge clk_i) begin
        if (rf_we) rf[exToWb_q.uop_info.rd] <= wdata;
    end

    // Decode read ports and the a0 tap, each bypassing the write in flight this cycle
    always_comb begin
        rf_rdata1_o = '0;
        rf_rdata2_o = '0;
        if (rf_raddr1_i != 5'd0)
            rf_rdata1_o = (rf_we && exToWb_q.uop_info.rd == rf_raddr1_i) ? wdata : rf[rf_raddr1_i];
        if (rf_raddr2_i != 5'd0)
            rf_rdata2_o = (rf_we && exToWb_q.uop_info.rd == rf_raddr2_i) ? wdata : rf[rf_raddr2_i];
        x10_rdata = (rf_we && exToWb_q.uop_info.rd == 5'd10) ? wdata : rf[10];
    end

    // WB->EX forward path; stays valid in HALT since the payload is still resident
    always_comb begin
        wb_fwd_valid_o = wb_valid_q && exToWb_q.uop_info.rd_wen && (exToWb_q.uop_info.rd != 5'd0);
        wb_fwd_rd_o    = exToWb_q.uop_info.rd;
        wb_fwd_data_o  = wdata;
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        retire_cnt_q <= '0;
        else if (wb_fire) retire_cnt_q <= retire_cnt_q + CNT_W'(1);
    end

    // Capture a0 on the RUN->HALT transition
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                  halt_code_q <= '0;
        else if (state_q == RUN && state_d == HALT) halt_code_q <= x10_rdata;
    end

    assign retire_cnt_o = retire_cnt_q;
    assign halt_code_o  = halt_code_q;

`ifdef WBU_COMMIT_TRACE_EN
    // Per-retirement trace for difftest
    always_comb begin
        commit_valid_o = wb_fire;
        commit_pc_o    = exToWb_q.uop_info.pc;
        commit_wdata_o = rf_we ? wdata : '0;
    end
`endif

endmodule

// File: tb/tb_pipe_wbu.sv
// Directed testbench for pipe_wbu: reset, ALU and load writeback, x0,
// back-to-back retirement, EBREAK halt and asynchronous reset.
module tb_pipe_wbu;
    import pipe_wbu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    exToWb_t     ex_in;
    logic        ex_valid;
    logic        wb_ready;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        halt;
    logic [31:0] halt_code;
    logic [63:0] retire_cnt;
`ifdef WBU_COMMIT_TRACE_EN
    logic        commit_valid;
    pc_t         commit_pc;
    logic [31:0] commit_wdata;
`endif

    int compared = 0;
    int mismatched = 0;

    pipe_wbu #(.XLEN(32), .CNT_W(64)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .exToWb_i       (ex_in),
        .ex_valid_i     (ex_valid),
        .wb_ready_o     (wb_ready),
        .wb_fwd_valid_o (fwd_valid),
        .wb_fwd_rd_o    (fwd_rd),
        .wb_fwd_data_o  (fwd_data),
        .rf_raddr1_i    (raddr1),
        .rf_raddr2_i    (raddr2),
        .rf_rdata1_o    (rdata1),
        .rf_rdata2_o    (rdata2),
        .halt_o         (halt),
        .halt_code_o    (halt_code),
`ifdef WBU_COMMIT_TRACE_EN
        .commit_valid_o (commit_valid),
        .commit_pc_o    (commit_pc),
        .commit_wdata_o (commit_wdata),
`endif
        .retire_cnt_o   (retire_cnt)
    );

    always #5 clk = ~clk;

    // Stimulus driver: one uop on the EX->WB interface
    task automatic drive(input fu_op_t op, input logic [4:0] rd, input logic wen,
                         input logic [31:0] alu, input logic [31:0] lsu, input logic v);
        ex_in.uop_info.pc     = 32'h8000_0000 + {22'd0, rd, 5'd0};
        ex_in.uop_info.fu_op  = op;
        ex_in.uop_info.rd     = rd;
        ex_in.uop_info.rd_wen = wen;
        ex_in.alu_res         = alu;
        ex_in.lsu_res         = lsu;
        ex_valid              = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        compared++;
        if (wb_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready got %b want 1", wb_ready); end
        compared++;
        if (halt !== 1'b0) begin mismatched++; $display("FAIL reset_halt got %b want 0", halt); end
        compared++;
        if (halt_code !== 32'h0) begin mismatched++; $display("FAIL reset_halt_code got %h want 0", halt_code); end
        compared++;
        if (retire_cnt !== 64'd0) begin mismatched++; $display("FAIL reset_retire got %0d want 0", retire_cnt); end
        compared++;
        if (fwd_valid !== 1'b0) begin mismatched++; $display("FAIL reset_fwd_valid got %b want 0", fwd_valid); end
    endtask

    task automatic test_addi();
        step();
        drive(ALU, 5'd5, 1'b1, 32'h1234, 32'h0, 1'b1);
        raddr1 = 5'd5;
        step();
        drive(ALU, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        compared++;
        if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'h1234) begin
            mismatched++; $display("FAIL addi_fwd got v=%b rd=%0d d=%h want v=1 rd=5 d=1234", fwd_valid, fwd_rd, fwd_data);
        end
        compared++;
        if (rdata1 !== 32'h1234) begin mismatched++; $display("FAIL addi_bypass got %h want 1234", rdata1); end
        compared++;
        if (retire_cnt !== 64'd0) begin mismatched++; $display("FAIL addi_cnt_before got %0d want 0", retire_cnt); end
        step();
        compared++;
        if (rdata1 !== 32'h1234) begin mismatched++; $display("FAIL addi_array got %h want 1234", rdata1); end
        compared++;
        if (retire_cnt !== 64'd1) begin mismatched++; $display("FAIL addi_cnt got %0d want 1", retire_cnt); end
        compared++;
        if (fwd_valid !== 1'b0) begin mismatched++; $display("FAIL addi_fwd_idle got %b want 0", fwd_valid); end
    endtask

    task automatic test_load();
        drive(LOAD, 5'd7, 1'b1, 32'hDEAD, 32'hBEEF, 1'b1);
        raddr2 = 5'd7;
        step();
        ex_valid = 1'b0;
        compared++;
        if (fwd_valid !== 1'b1 || fwd_data !== 32'hBEEF) begin
            mismatched++; $display("FAIL load_fwd got v=%b d=%h want v=1 d=beef", fwd_valid, fwd_data);
        end
        compared++;
        if (rdata2 !== 32'hBEEF) begin mismatched++; $display("FAIL load_bypass got %h want beef", rdata2); end
        step();
        compared++;
        if (rdata2 !== 32'hBEEF) begin mismatched++; $display("FAIL load_array got %h want beef", rdata2); end
        compared++;
        if (retire_cnt !== 64'd2) begin mismatched++; $display("FAIL load_cnt got %0d want 2", retire_cnt); end
    endtask

    task automatic test_x0();
        drive(ALU, 5'd0, 1'b1, 32'hFFFF, 32'h0, 1'b1);
        raddr1 = 5'd0;
        step();
        ex_valid = 1'b0;
        compared++;
        if (fwd_valid !== 1'b0) begin mismatched++; $display("FAIL x0_fwd got %b want 0", fwd_valid); end
        compared++;
        if (rdata1 !== 32'h0) begin mismatched++; $display("FAIL x0_bypass got %h want 0", rdata1); end
        step();
        compared++;
        if (rdata1 !== 32'h0) begin mismatched++; $display("FAIL x0_array got %h want 0", rdata1); end
        compared++;
        if (retire_cnt !== 64'd3) begin mismatched++; $display("FAIL x0_cnt got %0d want 3", retire_cnt); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            drive(ALU, 5'(11 + i), 1'b1, 32'h100 + 32'(i), 32'h0, 1'b1);
            compared++;
            if (wb_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready[%0d] got %b want 1", i, wb_ready); end
            step();
        end
        ex_valid = 1'b0;
        step();
        compared++;
        if (retire_cnt !== 64'd13) begin mismatched++; $display("FAIL b2b_cnt got %0d want 13", retire_cnt); end
        raddr1 = 5'd11;
        raddr2 = 5'd20;
        #1;
        compared++;
        if (rdata1 !== 32'h100 || rdata2 !== 32'h109) begin
            mismatched++; $display("FAIL b2b_regs got x11=%h x20=%h want 100/109", rdata1, rdata2);
        end
    endtask

    task automatic test_halt();
        drive(ALU, 5'd10, 1'b1, 32'h2A, 32'h0, 1'b1);
        step();
        drive(EBREAK, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1);
        step();
        drive(ALU, 5'd12, 1'b1, 32'h7777, 32'h0, 1'b1);
        step();
        compared++;
        if (halt !== 1'b1) begin mismatched++; $display("FAIL halt_flag got %b want 1", halt); end
        compared++;
        if (halt_code !== 32'h2A) begin mismatched++; $display("FAIL halt_code got %h want 2a", halt_code); end
        compared++;
        if (wb_ready !== 1'b0) begin mismatched++; $display("FAIL halt_ready got %b want 0", wb_ready); end
        compared++;
        if (retire_cnt !== 64'd15) begin mismatched++; $display("FAIL halt_cnt got %0d want 15", retire_cnt); end
        compared++;
        if (fwd_valid !== 1'b1 || fwd_rd !== 5'd12) begin
            mismatched++; $display("FAIL halt_fwd got v=%b rd=%0d want v=1 rd=12", fwd_valid, fwd_rd);
        end
        drive(ALU, 5'd11, 1'b1, 32'h5555, 32'h0, 1'b1);
        raddr1 = 5'd12;
        raddr2 = 5'd11;
        repeat (3) step();
        compared++;
        if (rdata1 !== 32'h101 || rdata2 !== 32'h100) begin
            mismatched++; $display("FAIL halt_no_write got x12=%h x11=%h want 101/100", rdata1, rdata2);
        end
        compared++;
        if (retire_cnt !== 64'd15 || halt !== 1'b1) begin
            mismatched++; $display("FAIL halt_frozen got cnt=%0d halt=%b want 15/1", retire_cnt, halt);
        end
        ex_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        compared++;
        if (halt !== 1'b0 || retire_cnt !== 64'd0 || halt_code !== 32'h0) begin
            mismatched++; $display("FAIL halt_reset got halt=%b cnt=%0d code=%h want 0/0/0", halt, retire_cnt, halt_code);
        end
        step();
        #1 rst = 1'b0;
    endtask

    task automatic test_async_reset();
        step();
        drive(ALU, 5'd12, 1'b1, 32'hAAAA, 32'h0, 1'b1);
        raddr1 = 5'd12;
        step();
        ex_valid = 1'b0;
        compared++;
        if (fwd_valid !== 1'b1 || rdata1 !== 32'hAAAA) begin
            mismatched++; $display("FAIL arst_pre got v=%b x12=%h want 1/aaaa", fwd_valid, rdata1);
        end
        #2 rst = 1'b1;
        #1;
        compared++;
        if (fwd_valid !== 1'b0 || wb_ready !== 1'b1) begin
            mismatched++; $display("FAIL arst_drop got fwd=%b ready=%b want 0/1", fwd_valid, wb_ready);
        end
        step();
        #1 rst = 1'b0;
        step();
        compared++;
        if (rdata1 !== 32'h101) begin mismatched++; $display("FAIL arst_no_write got %h want 101", rdata1); end
        compared++;
        if (retire_cnt !== 64'd0) begin mismatched++; $display("FAIL arst_cnt got %0d want 0", retire_cnt); end
    endtask

    initial begin
        drive(ALU, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        raddr1 = 5'd0;
        raddr2 = 5'd0;
        #12 rst = 1'b0;
        #1;
        test_reset();
        test_addi();
        test_load();
        test_x0();
        test_back_to_back();
        test_halt();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
